ovrd_clamp_sequencer: RTL and testbench

//  Multi-cycle controller for the overdrive cubic soft-clip; serves two sample channels
//  (ch0/ch1, e.g. L/R) through ONE shared external signed multiplier.

---
 rtl/ovrd_clamp_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_ovrd_clamp_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ovrd_clamp_sequencer.sv
// ovrd_clamp_sequencer: cubic soft-clip controller for two sample channels
// sharing one external signed multiplier.
//   y = x >= one ? +half : x <= -one ? -half : (3x - x^3) / 4
// Round-robin arbitration. x^2 then x^3 are computed on the shared multiplier.
// The saturation region bypasses the multiplier. The result is returned on a
// valid/ready output that supports backpressure.
// Ports:
//   i_clk, i_rst_n               clock, asynchronous active-low reset
//   i_chN_sample/valid, o_chN_ready  per-channel input handshake (N = 0, 1)
//   o_mul_en/o_mul_a/o_mul_b     operands for the shared multiplier
//   i_mul_res                    full signed product, returned combinationally
//   o_sample/o_ch/o_valid/i_ready  clipped output with backpressure
// Optional feature OVRD_SEQ_SATCNT_EN adds i_sat_clr and o_sat_count,
// a saturating 16-bit count of samples that took the saturation path.
module ovrd_clamp_sequencer #(
  parameter int unsigned bits_per_level = 12,
  parameter int unsigned fxp_size       = 32
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic signed [fxp_size-1:0]     i_ch0_sample,
  input  logic                           i_ch0_valid,
  output logic                           o_ch0_ready,
  input  logic signed [fxp_size-1:0]     i_ch1_sample,
  input  logic                           i_ch1_valid,
  output logic                           o_ch1_ready,
  output logic                           o_mul_en,
  output logic signed [fxp_size-1:0]     o_mul_a,
  output logic signed [fxp_size-1:0]     o_mul_b,
  input  logic signed [2*fxp_size-1:0]   i_mul_res,
  output logic signed [fxp_size-1:0]     o_sample,
  output logic                           o_ch,
  output logic                           o_valid,
`ifdef OVRD_SEQ_SATCNT_EN
  input  logic                           i_sat_clr,
  output logic [15:0]                    o_sat_count,
`endif
  input  logic                           i_ready
);

  localparam int unsigned PW = 2 * fxp_size;
  localparam int unsigned EW = fxp_size + 3;

  localparam logic signed [fxp_size-1:0] ONE      = fxp_size'(1) << bits_per_level;
  localparam logic signed [fxp_size-1:0] NEG_ONE  = -ONE;
  localparam logic signed [fxp_size-1:0] HALF     = ONE >>> 1;
  localparam logic signed [fxp_size-1:0] NEG_HALF = -HALF;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SQ   = 2'd1;
  localparam logic [1:0] CU   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]                 state_q, state_d;
  logic signed [fxp_size-1:0] x_q, x_d;
  logic                       ch_q, ch_d;
  logic                       last_q, last_d;
  logic signed [fxp_size-1:0] sample_q, sample_d;
  logic                       valid_q, valid_d;
  logic                       mul_en_q, mul_en_d;
  logic signed [fxp_size-1:0] mul_a_q, mul_a_d;
  logic signed [fxp_size-1:0] mul_b_q, mul_b_d;

  logic                       rdy0, rdy1, grant, sat_fire;
  logic signed [fxp_size-1:0] x_in;
  logic signed [PW-1:0]       prod_sh;
  logic signed [EW-1:0]       x_ext, cu_ext, res3, res_sh;

  // Next-state, datapath and handshake decode
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    ch_d     = ch_q;
    last_d   = last_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    mul_en_d = 1'b0;
    mul_a_d  = '0;
    mul_b_d  = '0;
    rdy0     = 1'b0;
    rdy1     = 1'b0;
    sat_fire = 1'b0;

    // Contention goes to the channel not served last; otherwise to whoever is valid
    grant    = (i_ch0_valid && i_ch1_valid) ? ~last_q : i_ch1_valid;
    x_in     = grant ? i_ch1_sample : i_ch0_sample;

    // Product rescale; low fxp_size bits suffice while |x| < one
    prod_sh  = i_mul_res >>> bits_per_level;
    x_ext    = EW'(x_q);
    cu_ext   = EW'(fxp_size'(prod_sh));
    res3     = x_ext + (x_ext <<< 1) - cu_ext;
    res_sh   = res3 >>> 2;

    case (state_q)
      IDLE: begin
        if (i_ch0_valid || i_ch1_valid) begin
          rdy0   = ~grant;
          rdy1   = grant;
          x_d    = x_in;
          ch_d   = grant;
          last_d = grant;
          if (x_in >= ONE) begin
            sample_d = HALF;
            valid_d  = 1'b1;
            sat_fire = 1'b1;
            state_d  = DONE;
          end else if (x_in <= NEG_ONE) begin
            sample_d = NEG_HALF;
            valid_d  = 1'b1;
            sat_fire = 1'b1;
            state_d  = DONE;
          end else begin
            mul_en_d = 1'b1;
            mul_a_d  = x_in;
            mul_b_d  = x_in;
            state_d  = SQ;
          end
        end
      end
      SQ: begin
        // x^2 goes straight back out as operand A for x^3
        mul_en_d = 1'b1;
        mul_a_d  = fxp_size'(prod_sh);
        mul_b_d  = x_q;
        state_d  = CU;
      end
      CU: begin
        sample_d = fxp_size'(res_sh);
        valid_d  = 1'b1;
        state_d  = DONE;
      end
      default: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  // State and output registers; ch0 holds priority out of reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      ch_q     <= 1'b0;
      last_q   <= 1'b1;
      sample_q <= '0;
      valid_q  <= 1'b0;
      mul_en_q <= 1'b0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      ch_q     <= ch_d;
      last_q   <= last_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      mul_en_q <= mul_en_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
    end
  end

  assign o_ch0_ready = rdy0;
  assign o_ch1_ready = rdy1;
  assign o_mul_en    = mul_en_q;
  assign o_mul_a     = mul_a_q;
  assign o_mul_b     = mul_b_q;
  assign o_sample    = sample_q;
  assign o_ch        = ch_q;
  assign o_valid     = valid_q;

`ifdef OVRD_SEQ_SATCNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  // Saturation-path counter; clear beats increment, sticks at all-ones
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (i_sat_clr) begin
      sat_cnt_d = '0;
    end else if (sat_fire && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign o_sat_count = sat_cnt_q;
`else
  logic unused_sat;
  assign unused_sat = sat_fire;
`endif

endmodule

// File: tb/tb_ovrd_clamp_sequencer.sv
// Bench for ovrd_clamp_sequencer: directed and random transactions against a
// behavioural soft-clip model built from floor division and a round-robin flag.
module tb_ovrd_clamp_sequencer;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [31:0] s0, s1;
  logic               v0, v1, r0, r1;
  logic               mul_en;
  logic signed [31:0] mul_a, mul_b;
  logic signed [63:0] mul_res;
  logic signed [31:0] o_sample;
  logic               o_ch, o_valid, rdy;
`ifdef OVRD_SEQ_SATCNT_EN
  logic               sat_clr;
  logic [15:0]        sat_count;
  int                 exp_sat;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit last    = 1'b1;

  always #5 clk = ~clk;

  // Shared multiplier model
  assign mul_res = longint'(mul_a) * longint'(mul_b);

  ovrd_clamp_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ch0_sample(s0), .i_ch0_valid(v0), .o_ch0_ready(r0),
    .i_ch1_sample(s1), .i_ch1_valid(v1), .o_ch1_ready(r1),
    .o_mul_en(mul_en), .o_mul_a(mul_a), .o_mul_b(mul_b), .i_mul_res(mul_res),
    .o_sample(o_sample), .o_ch(o_ch), .o_valid(o_valid),
`ifdef OVRD_SEQ_SATCNT_EN
    .i_sat_clr(sat_clr), .o_sat_count(sat_count),
`endif
    .i_ready(rdy)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint clip(input longint x);
    longint sq, cu;
    if (x >= 4096) return 2048;
    if (x <= -4096) return -2048;
    sq = fdiv(x * x, 4096);
    cu = fdiv(sq * x, 4096);
    return fdiv(3 * x - cu, 4);
  endfunction

  // One transaction from IDLE (called at posedge+1), back to IDLE at posedge+1
  task automatic run_one(input bit m0, input bit m1, input int x0, input int x1, input int stall);
    bit     g;
    longint x, sqm;
    bit     sat;
    int     n, en_cnt;
    g   = (m0 && m1) ? !last : m1;
    x   = g ? longint'(x1) : longint'(x0);
    sat = (x >= 4096) || (x <= -4096);
    sqm = fdiv(x * x, 4096);
    s0 = x0; s1 = x1; v0 = m0; v1 = m1; rdy = (stall == 0);
    #1;
    chk("ready0", r0, !g);
    chk("ready1", r1, g);
    @(posedge clk); #1;
    last = g;
`ifdef OVRD_SEQ_SATCNT_EN
    if (sat_clr) exp_sat = 0; else if (sat) exp_sat++;
`endif
    v0 = 1'b0; v1 = 1'b0;
    n = 1; en_cnt = 0;
    while (o_valid !== 1'b1 && n < 8) begin
      if (mul_en === 1'b1) en_cnt++;
      if (!sat && n == 1) begin
        chk("sq_a", mul_a, x);
        chk("sq_b", mul_b, x);
      end
      if (!sat && n == 2) chk("cu_a", mul_a, sqm);
      @(posedge clk); #1;
      n++;
    end
    if (mul_en === 1'b1) en_cnt++;
    chk("latency", n, sat ? 1 : 3);
    chk("mul_en_cycles", en_cnt, sat ? 0 : 2);
    chk("sample", o_sample, clip(x));
    chk("ch", o_ch, g);
    for (int k = 0; k < stall; k++) begin
      v0 = 1'b1; v1 = 1'b1;
      #1;
      chk("stall_valid", o_valid, 1);
      chk("stall_sample", o_sample, clip(x));
      chk("stall_ch", o_ch, g);
      chk("stall_rdy", {r0, r1}, 0);
      @(posedge clk); #1;
    end
    v0 = 1'b0; v1 = 1'b0; rdy = 1'b1;
    @(posedge clk); #1;
    chk("release", o_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; s0 = '0; s1 = '0; v0 = 1'b0; v1 = 1'b0; rdy = 1'b1;
`ifdef OVRD_SEQ_SATCNT_EN
    sat_clr = 1'b0; exp_sat = 0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_sample", o_sample, 0);
    chk("rst_ch", o_ch, 0);
    chk("rst_mul", {mul_en, mul_a, mul_b}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_one(1, 0, 2048, 0, 0);
    run_one(1, 0, -2048, 0, 0);
    run_one(1, 0, 4095, 0, 0);
    run_one(1, 0, 4096, 0, 0);
    run_one(1, 0, -5000, 0, 0);
    run_one(0, 1, 0, 4096, 0);
    run_one(0, 1, 0, -4096, 0);
    run_one(0, 1, 0, 1000, 0);
    run_one(1, 0, 300, 0, 5);
    run_one(1, 0, 9000, 0, 5);

    // Reset while the cube is on the multiplier
    s0 = 2048; v0 = 1'b1; rdy = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0;
    @(posedge clk); #1;
    chk("in_cu_mul_en", mul_en, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_sample", o_sample, 0);
    chk("arst_mul", {mul_en, mul_a, mul_b}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    last = 1'b1;
`ifdef OVRD_SEQ_SATCNT_EN
    exp_sat = 0;
`endif
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) run_one(1, 1, 100 * i + 5, -100 * i - 7, 0);
    for (int i = 0; i < 3; i++) run_one(0, 1, 0, 1500 * i - 1500, 0);

    for (int i = 0; i < 40; i++) begin
      int m;
      m = int'($urandom_range(3, 1));
      run_one(m[0], m[1], int'($urandom_range(12000)) - 6000,
              int'($urandom_range(12000)) - 6000, int'($urandom_range(2)));
    end

`ifdef OVRD_SEQ_SATCNT_EN
    chk("sat_count", sat_count, exp_sat);
    sat_clr = 1'b1;
    run_one(1, 0, 5000, 0, 0);
    sat_clr = 1'b0;
    chk("sat_clr", sat_count, 0);
    for (int i = 0; i < 3; i++) run_one(1, 0, -4096 - i, 0, 0);
    chk("sat_count3", sat_count, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
